display_scan_mux: RTL and testbench

Parametrised time-multiplexed driver for common-select seven-segment displays. It latches a packed vector of 6-bit character codes into a shadow register. It then scans `NUM_DIGITS` digits with a blanking guard against ghosting, 16-level PWM brightness, per-digit decimal points and optional per-digit blinking. It sits between the CPU's display/IO register file and the board's segment/select pins.

---
 rtl/display_pkg.sv | 36 +++
 rtl/seg_decode.sv | 12 +
 rtl/display_scan_mux.sv | 145 ++++++++++++++
 tb/tb_display_scan_mux.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and the character-to-segment table for the seven-segment scan driver.
// Segment byte order is {a,b,c,d,e,f,g,dp}; the table never sets dp.
package display_pkg;

   localparam logic [5:0] CODE_BLANK = 6'd36;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   typedef enum logic {BLANK, ON} scan_state_t;

   function automatic logic [7:0] seg_lut(input logic [5:0] code);
      logic [7:0] s;
      case (code)
         6'd0:  s = 8'hFC;  6'd1:  s = 8'h60;  6'd2:  s = 8'hDA;  6'd3:  s = 8'hF2;
         6'd4:  s = 8'h66;  6'd5:  s = 8'hB6;  6'd6:  s = 8'hBE;  6'd7:  s = 8'hE0;
         6'd8:  s = 8'hFE;  6'd9:  s = 8'hF6;  6'd10: s = 8'hEE;  6'd11: s = 8'h3E;
         6'd12: s = 8'h9C;  6'd13: s = 8'h7A;  6'd14: s = 8'h9E;  6'd15: s = 8'h8E;
         // G..Z: best-effort glyphs, some letters share shapes with digits
         6'd16: s = 8'hBC;  6'd17: s = 8'h6E;  6'd18: s = 8'h0C;  6'd19: s = 8'h78;
         6'd20: s = 8'h5E;  6'd21: s = 8'h1C;  6'd22: s = 8'hA8;  6'd23: s = 8'h2A;
         6'd24: s = 8'h3A;  6'd25: s = 8'hCE;  6'd26: s = 8'hE6;  6'd27: s = 8'h0A;
         6'd28: s = 8'hB6;  6'd29: s = 8'h1E;  6'd30: s = 8'h7C;  6'd31: s = 8'h38;
         6'd32: s = 8'h54;  6'd33: s = 8'h6E;  6'd34: s = 8'h76;  6'd35: s = 8'hDA;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational character decode with the per-digit decimal point merged in.
module seg_decode
   import display_pkg::*;
(
   input  logic [5:0] code,
   input  logic       dp,
   output logic [7:0] seg
);

   assign seg = seg_lut(code) | (8'(dp) << SEG_DP);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment scanner: shadow capture at frame boundaries, blanking guard, PWM.
// Optional per-digit blinking is compiled in with `define DISPLAY_BLINK_EN.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int CODE_W       = 6,
   parameter int CLK_HZ       = 100_000_000,
   parameter int SCAN_HZ      = 1000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_FRAMES = 62
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_DIGITS*CODE_W-1:0] content,
   input  logic [NUM_DIGITS-1:0]        dp,
   input  logic                         load,
   input  logic [3:0]                   brightness,
   input  logic [NUM_DIGITS-1:0]        blink_mask,
   output logic [NUM_DIGITS-1:0]        com,
   output logic [7:0]                   seg_out,
   output logic                         frame_done
);

   localparam int DWELL = CLK_HZ / SCAN_HZ;
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DW_W-1:0]  DW_LAST    = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0]  BLANK_LAST = DW_W'(BLANK_CYCLES - 1);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

   logic [DW_W-1:0]  dwell_cnt, dwell_nxt;
   logic [DIG_W-1:0] digit, digit_nxt;
   logic [3:0]       pwm_cnt;
   scan_state_t      state, state_nxt;
   logic             pending;
   logic             boundary;

   logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_code;
   logic [NUM_DIGITS-1:0]             shadow_dp;

   logic [CODE_W-1:0]     cur_code;
   logic                  cur_dp;
   logic [7:0]            dec_seg;
   logic                  blank_digit;
   logic [NUM_DIGITS-1:0] com_nxt;
   logic [7:0]            seg_nxt;

   assign boundary = (dwell_cnt == DW_LAST) && (digit == DIG_LAST);
   assign cur_code = shadow_code[digit];
   assign cur_dp   = shadow_dp[digit];

   seg_decode u_dec (
      .code (cur_code),
      .dp   (cur_dp),
      .seg  (dec_seg)
   );

`ifdef DISPLAY_BLINK_EN
   localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [BF_W-1:0] blink_cnt;
   logic            blink_phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (boundary) begin
         if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign blank_digit = blink_phase & blink_mask[digit];
`else
   logic unused_blink;
   assign unused_blink = ^blink_mask;
   assign blank_digit  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell_cnt <= '0;
         digit     <= '0;
         pwm_cnt   <= '0;
         state     <= BLANK;
      end else begin
         dwell_cnt <= dwell_nxt;
         digit     <= digit_nxt;
         pwm_cnt   <= pwm_cnt + 4'd1;
         state     <= state_nxt;
      end
   end

   // A load landing on the boundary cycle itself is taken immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending     <= 1'b0;
         shadow_code <= {NUM_DIGITS{CODE_BLANK}};
         shadow_dp   <= '0;
      end else if (boundary && (pending || load)) begin
         pending     <= 1'b0;
         shadow_code <= content;
         shadow_dp   <= dp;
      end else if (load) begin
         pending <= 1'b1;
      end
   end

   always_comb begin
      dwell_nxt = dwell_cnt + DW_W'(1);
      digit_nxt = digit;
      state_nxt = state;
      com_nxt   = '0;
      seg_nxt   = 8'h00;
      if (dwell_cnt == DW_LAST) begin
         dwell_nxt = '0;
         digit_nxt = (digit == DIG_LAST) ? '0 : digit + 1'b1;
         state_nxt = (BLANK_CYCLES == 0) ? ON : BLANK;
      end else if (dwell_cnt == BLANK_LAST) begin
         state_nxt = ON;
      end
      if (state == ON) begin
         if (pwm_cnt <= brightness) com_nxt[digit] = 1'b1;
         if (!blank_digit) seg_nxt = dec_seg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         com        <= '0;
         seg_out    <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         com        <= com_nxt;
         seg_out    <= seg_nxt;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: expected outputs are derived from the absolute
// cycle position since reset and queued as each cycle's stimulus is applied.
module tb_display_scan_mux;

   localparam int ND    = 4;
   localparam int DWELL = 10;
   localparam int BLNK  = 2;
   localparam int FRAME = ND * DWELL;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [ND*6-1:0] content;
   logic [ND-1:0]   dp;
   logic            load;
   logic [3:0]      brightness;
   logic [ND-1:0]   blink_mask;
   logic [ND-1:0]   com;
   logic [7:0]      seg_out;
   logic            frame_done;

   always #5 clk = ~clk;

   display_scan_mux #(
      .NUM_DIGITS(ND), .CODE_W(6), .CLK_HZ(1000), .SCAN_HZ(100),
      .BLANK_CYCLES(BLNK), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .content(content), .dp(dp), .load(load),
      .brightness(brightness), .blink_mask(blink_mask),
      .com(com), .seg_out(seg_out), .frame_done(frame_done)
   );

   typedef struct packed {
      logic [ND-1:0] com;
      logic [7:0]    seg;
      logic          fd;
      logic [31:0]   pos;
   } exp_t;

   exp_t            sb[$];
   int              n_cmp = 0;
   int              n_bad = 0;
   int              mpos;
   logic [ND*6-1:0] mshadow;
   logic [ND-1:0]   mdp;
   logic            mpend;

   function automatic logic [7:0] ref_seg(input logic [5:0] c);
      logic [7:0] t [0:35];
      t = '{8'hFC,8'h60,8'hDA,8'hF2,8'h66,8'hB6,8'hBE,8'hE0,8'hFE,8'hF6,8'hEE,8'h3E,
            8'h9C,8'h7A,8'h9E,8'h8E,8'hBC,8'h6E,8'h0C,8'h78,8'h5E,8'h1C,8'hA8,8'h2A,
            8'h3A,8'hCE,8'hE6,8'h0A,8'hB6,8'h1E,8'h7C,8'h38,8'h54,8'h6E,8'h76,8'hDA};
      return (c < 6'd36) ? t[c] : 8'h00;
   endfunction

   function automatic bit blink_on(input int p);
`ifdef DISPLAY_BLINK_EN
      return ((p / FRAME) / 2) % 2 == 1;
`else
      return (p < 0);
`endif
   endfunction

   task automatic model_reset();
      mpos    = 0;
      mshadow = {ND{6'd36}};
      mdp     = '0;
      mpend   = 1'b0;
   endtask

   // One clock: queue what the DUT must show after this edge, then update the model.
   task automatic step();
      exp_t e;
      int   dw, dg;
      dw    = mpos % DWELL;
      dg    = (mpos / DWELL) % ND;
      e.pos = mpos;
      e.com = '0;
      e.seg = 8'h00;
      e.fd  = (mpos % FRAME) == FRAME - 1;
      if (dw >= BLNK) begin
         if ((mpos % 16) <= int'(brightness)) e.com = ND'(1) << dg;
         e.seg = ref_seg(mshadow[dg*6 +: 6]) | {7'b0, mdp[dg]};
         if (blink_on(mpos) && blink_mask[dg]) e.seg = 8'h00;
      end
      sb.push_back(e);
      if (e.fd && (mpend || load)) begin
         mshadow = content;
         mdp     = dp;
         mpend   = 1'b0;
      end else if (load) begin
         mpend = 1'b1;
      end
      mpos++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic skip_to(input int ph);
      exp_t e;
      while ((mpos % FRAME) != ph) begin
         step();
         e = sb.pop_front();
      end
   endtask

   task automatic test_reset();
      exp_t e;
      int   pulses;
      logic [ND-1:0] sel;
      n_cmp++;
      if ({com, seg_out, frame_done} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got com=%b seg=%h fd=%b want all 0", com, seg_out, frame_done);
      end
      rst = 1'b1;
      model_reset();
      pulses = 0;
      repeat (2 * FRAME) begin
         step();
         e = sb.pop_front();
         pulses += int'(frame_done);
         n_cmp++;
         if ({com, seg_out, frame_done} !== {e.com, e.seg, e.fd}) begin
            n_bad++;
            $display("FAIL reset_scan pos=%0d got com=%b seg=%h fd=%b want com=%b seg=%h fd=%b",
                     e.pos, com, seg_out, frame_done, e.com, e.seg, e.fd);
         end
         if (e.pos % DWELL == 5) begin
            sel = ND'(1) << ((e.pos / DWELL) % ND);
            n_cmp++;
            if (com !== sel) begin
               n_bad++;
               $display("FAIL reset_select pos=%0d got com=%b want %b", e.pos, com, sel);
            end
         end
      end
      n_cmp++;
      if (pulses != 2) begin
         n_bad++;
         $display("FAIL reset_frame_done got %0d pulses want 2", pulses);
      end
   endtask

   task automatic test_load_mid();
      exp_t e;
      int   tgt, dg;
      logic [3:0][7:0] kv;
      kv = {8'hF2, 8'hDB, 8'h60, 8'hFC};
      skip_to(DWELL + 3);
      content = {6'd3, 6'd2, 6'd1, 6'd0};
      dp      = 4'b0100;
      load    = 1'b1;
      tgt     = mpos / FRAME + 1;
      step();
      load = 1'b0;
      e = sb.pop_front();
      while (mpos < (tgt + 1) * FRAME) begin
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({com, seg_out, frame_done} !== {e.com, e.seg, e.fd}) begin
            n_bad++;
            $display("FAIL load_mid pos=%0d got com=%b seg=%h fd=%b want com=%b seg=%h fd=%b",
                     e.pos, com, seg_out, frame_done, e.com, e.seg, e.fd);
         end
         if (int'(e.pos) / FRAME == tgt && e.pos % DWELL >= BLNK) begin
            dg = (e.pos / DWELL) % ND;
            n_cmp++;
            if (seg_out !== kv[dg]) begin
               n_bad++;
               $display("FAIL load_mid_value digit=%0d got seg=%h want %h", dg, seg_out, kv[dg]);
            end
         end
      end
   endtask

   task automatic test_load_boundary();
      exp_t e;
      skip_to(FRAME - 1);
      content = {6'd7, 6'd6, 6'd5, 6'd4};
      dp      = 4'b0000;
      load    = 1'b1;
      step();
      load = 1'b0;
      e = sb.pop_front();
      repeat (DWELL) begin
         step();
         e = sb.pop_front();
         if (e.pos % DWELL >= BLNK) begin
            n_cmp++;
            if (seg_out !== 8'h66 || com !== 4'b0001) begin
               n_bad++;
               $display("FAIL load_boundary pos=%0d got com=%b seg=%h want com=0001 seg=66",
                        e.pos, com, seg_out);
            end
         end
      end
   endtask

   task automatic test_pwm();
      exp_t e;
      int   act, on_cyc;
      content = {4{6'd8}};
      load    = 1'b1;
      step();
      load = 1'b0;
      e = sb.pop_front();
      skip_to(0);
      brightness = 4'd3;
      act = 0;
      repeat (2 * FRAME) begin
         step();
         e = sb.pop_front();
         act += int'(com != '0);
         n_cmp++;
         if ({com, seg_out, frame_done} !== {e.com, e.seg, e.fd}) begin
            n_bad++;
            $display("FAIL pwm3 pos=%0d got com=%b seg=%h want com=%b seg=%h",
                     e.pos, com, seg_out, e.com, e.seg);
         end
      end
      // 80 consecutive cycles = 5 PWM periods, each with 4 lit slots; of those
      // slots the ones landing in a blank window are suppressed.
      n_cmp++;
      if (act == 0 || act > 20) begin
         n_bad++;
         $display("FAIL pwm3_duty got %0d active cycles want 1..20", act);
      end
      brightness = 4'd15;
      act    = 0;
      on_cyc = 0;
      repeat (2 * FRAME) begin
         step();
         e = sb.pop_front();
         if (e.pos % DWELL >= BLNK) begin
            on_cyc++;
            act += int'(com != '0);
            n_cmp++;
            if (seg_out !== 8'hFE) begin
               n_bad++;
               $display("FAIL pwm15_seg pos=%0d got seg=%h want fe", e.pos, seg_out);
            end
         end
      end
      n_cmp++;
      if (act != on_cyc) begin
         n_bad++;
         $display("FAIL pwm15_duty got %0d active want %0d", act, on_cyc);
      end
   endtask

   task automatic test_oob();
      exp_t e;
      content = {6'd40, 6'd63, 6'd36, 6'd37};
      dp      = 4'b1111;
      load    = 1'b1;
      step();
      load = 1'b0;
      e = sb.pop_front();
      skip_to(0);
      repeat (FRAME) begin
         step();
         e = sb.pop_front();
         if (e.pos % DWELL >= BLNK) begin
            n_cmp++;
            if (seg_out !== 8'h01) begin
               n_bad++;
               $display("FAIL oob_code pos=%0d got seg=%h want 01", e.pos, seg_out);
            end
         end
      end
      dp = 4'b0000;
   endtask

   task automatic test_blink();
      exp_t e;
      int   dg;
      logic [7:0] want;
      content = {4{6'd8}};
      load    = 1'b1;
      step();
      load = 1'b0;
      e = sb.pop_front();
      skip_to(0);
      blink_mask = 4'b0001;
      repeat (4 * FRAME) begin
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({com, seg_out, frame_done} !== {e.com, e.seg, e.fd}) begin
            n_bad++;
            $display("FAIL blink pos=%0d got com=%b seg=%h want com=%b seg=%h",
                     e.pos, com, seg_out, e.com, e.seg);
         end
         if (e.pos % DWELL >= BLNK) begin
            dg   = (e.pos / DWELL) % ND;
            want = (dg == 0 && blink_on(e.pos)) ? 8'h00 : 8'hFE;
            n_cmp++;
            if (seg_out !== want) begin
               n_bad++;
               $display("FAIL blink_digit pos=%0d digit=%0d got seg=%h want %h", e.pos, dg, seg_out, want);
            end
         end
      end
      blink_mask = 4'b0000;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      skip_to(2 * DWELL + 6);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({com, seg_out, frame_done} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_mid_async got com=%b seg=%h fd=%b want all 0", com, seg_out, frame_done);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (FRAME + 2) begin
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({com, seg_out, frame_done} !== {e.com, e.seg, e.fd}) begin
            n_bad++;
            $display("FAIL reset_mid_scan pos=%0d got com=%b seg=%h fd=%b want com=%b seg=%h fd=%b",
                     e.pos, com, seg_out, frame_done, e.com, e.seg, e.fd);
         end
      end
   endtask

   initial begin
      content    = '0;
      dp         = '0;
      load       = 1'b0;
      brightness = 4'd15;
      blink_mask = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_load_mid();
      test_load_boundary();
      test_pwm();
      test_oob();
      test_blink();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
